// File: rtl/kpn_pkg.sv
// Shared KPN definitions: default token width, delay-node states
// and a ceil-log2 helper for sizing pointers and counters.
package kpn_pkg;

  localparam int KPN_WORD_W = 16;

  typedef enum logic {
    PRELOAD = 1'b0,
    PASS    = 1'b1
  } kpn_state_e;

  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/kpn_sync_fifo.sv
// Synchronous FIFO for KPN token channels; registered write,
// combinational read of the head entry, synchronous clear.
// Ports: clk, rst_n, clear, push, pop, wdata, rdata, full, empty, level.
module kpn_sync_fifo
  import kpn_pkg::*;
#(
  parameter int WIDTH = KPN_WORD_W,
  parameter int DEPTH = 8,
  localparam int AW = log2c(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only the pointers define contents.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/kpn_delay_stream.sv
// KPN z^-DELAY node: emits DELAY tokens of INIT_VALUE, then
// forwards the input stream in order through a FIFO.
// Ports: clk, rst_n, restart, in_data/in_valid/in_ready,
// out_data/out_valid/out_ready, level, preload_done.
module kpn_delay_stream
  import kpn_pkg::*;
#(
  parameter int               WIDTH      = KPN_WORD_W,
  parameter int               DELAY      = 4,
  parameter int               DEPTH      = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     restart,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     preload_done
);

  localparam int CW = 17;
  localparam kpn_state_e RST_STATE = (DELAY > 0) ? PRELOAD : PASS;

  kpn_state_e       state;
  kpn_state_e       state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             push;
  logic             pop;
  logic             f_pop;
  logic [WIDTH-1:0] f_rdata;
  logic             f_full;
  logic             f_empty;

  // restart masks both handshakes so the offered token is dropped.
  assign in_ready = !f_full;
  assign push     = in_valid && in_ready && !restart;
  assign pop      = out_valid && out_ready && !restart;
  assign f_pop    = pop && (state == PASS);

  kpn_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (restart),
    .push  (push),
    .pop   (f_pop),
    .wdata (in_data),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      cnt   <= CW'(DELAY);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (restart) begin
      state_nxt = RST_STATE;
      cnt_nxt   = CW'(DELAY);
    end else if (pop && state == PRELOAD) begin
      cnt_nxt = cnt - CW'(1);
      if (cnt == CW'(1)) state_nxt = PASS;
    end
  end

  always_comb begin
    out_valid    = 1'b0;
    out_data     = f_rdata;
    preload_done = 1'b0;
    case (state)
      PRELOAD: begin
        out_valid = 1'b1;
        out_data  = INIT_VALUE;
      end
      PASS: begin
        out_valid    = !f_empty;
        preload_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_kpn_delay_stream.sv
// Bench for kpn_delay_stream: two instances (DELAY=4 and DELAY=0)
// against a queue-level token model plus directed literal checks.
module tb_kpn_delay_stream;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int LW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         rs   [2];
  logic         iv   [2];
  logic         ordy [2];
  logic         ir   [2];
  logic         ov   [2];
  logic         pd   [2];
  logic [W-1:0] id   [2];
  logic [W-1:0] od   [2];
  logic [LW-1:0] lv  [2];

  kpn_delay_stream #(
    .WIDTH(W), .DELAY(4), .DEPTH(D), .INIT_VALUE(16'h0000)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .restart(rs[0]),
    .in_data(id[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .level(lv[0]), .preload_done(pd[0])
  );

  kpn_delay_stream #(
    .WIDTH(W), .DELAY(0), .DEPTH(D), .INIT_VALUE(16'h0000)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .restart(rs[1]),
    .in_data(id[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .level(lv[1]), .preload_done(pd[1])
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Token model: remaining preload count plus a FIFO of tokens.
  int           pc [2];
  int           qh [2];
  int           qt [2];
  logic [W-1:0] qm [2][256];

  function automatic int dly_of(input int d);
    return (d == 0) ? 4 : 0;
  endfunction

  function automatic void mreset(input int d);
    pc[d] = dly_of(d);
    qh[d] = 0;
    qt[d] = 0;
  endfunction

  function automatic int msize(input int d);
    return qt[d] - qh[d];
  endfunction

  function automatic logic mvalid(input int d);
    return (pc[d] > 0) || (msize(d) > 0);
  endfunction

  function automatic logic mready(input int d);
    return msize(d) != D;
  endfunction

  function automatic logic [W-1:0] mdata(input int d);
    if (pc[d] > 0) return '0;
    return qm[d][qh[d] % 256];
  endfunction

  function automatic void mstep(input int d);
    logic pop_e;
    logic push_e;
    if (rs[d]) begin
      mreset(d);
    end else begin
      pop_e  = mvalid(d) && ordy[d];
      push_e = iv[d] && mready(d);
      if (pop_e) begin
        if (pc[d] > 0) pc[d]--;
        else qh[d]++;
      end
      if (push_e) begin
        qm[d][qt[d] % 256] = id[d];
        qt[d]++;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mreset(0);
      mreset(1);
    end else begin
      mstep(0);
      mstep(1);
    end
  end

  always @(negedge rst_n) begin
    mreset(0);
    mreset(1);
  end

  // Output capture of accepted tokens, and the per-cycle compare.
  logic [W-1:0] cap  [2][4096];
  int           ncap [2];
  int           lvmax;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("out_valid%0d", d), 32'(ov[d]), 32'(mvalid(d)));
      chk($sformatf("in_ready%0d", d), 32'(ir[d]), 32'(mready(d)));
      chk($sformatf("level%0d", d), 32'(lv[d]), 32'(msize(d)));
      chk($sformatf("preload_done%0d", d), 32'(pd[d]),
          32'(pc[d] == 0));
      if (mvalid(d))
        chk($sformatf("out_data%0d", d), 32'(od[d]), 32'(mdata(d)));
      if (rst_n && !rs[d] && ov[d] && ordy[d]) begin
        cap[d][ncap[d] % 4096] = od[d];
        ncap[d]++;
      end
    end
    if (32'(lv[0]) > lvmax) lvmax = 32'(lv[0]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic acc;
  int   sent;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rs[d] = 1'b0; iv[d] = 1'b0; ordy[d] = 1'b0; id[d] = '0;
      mreset(d);
      ncap[d] = 0;
    end
    lvmax = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_valid", 32'(ov[0]), 32'd1);
    chk("rst_a_data", 32'(od[0]), 32'd0);
    chk("rst_a_ready", 32'(ir[0]), 32'd1);
    chk("rst_a_level", 32'(lv[0]), 32'd0);
    chk("rst_a_done", 32'(pd[0]), 32'd0);
    chk("rst_b_valid", 32'(ov[1]), 32'd0);
    chk("rst_b_done", 32'(pd[1]), 32'd1);

    // Ordering on A, fill past full on B.
    rst_n = 1'b1;
    ncap[0] = 0;
    ncap[1] = 0;
    lvmax = 0;
    for (int k = 0; k < 14; k++) begin
      ordy[0] = 1'b1;
      iv[0] = (k < 6);
      id[0] = W'(k + 1);
      ordy[1] = 1'b0;
      iv[1] = (k < 10);
      id[1] = W'(16'h0A00 + k);
      tick();
      if (k == 2) chk("done_after3", 32'(pd[0]), 32'd0);
      if (k == 3) chk("done_after4", 32'(pd[0]), 32'd1);
    end
    iv[0] = 1'b0; ordy[0] = 1'b0; iv[1] = 1'b0;
    chk("order_count", 32'(ncap[0]), 32'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("order_%0d", i), 32'(cap[0][i]),
          (i < 4) ? 32'd0 : 32'(i - 3));
    chk("order_maxlevel", 32'(lvmax), 32'd4);
    chk("full_level", 32'(lv[1]), 32'd8);
    chk("full_ready", 32'(ir[1]), 32'd0);

    ncap[1] = 0;
    iv[1] = 1'b1; id[1] = 16'h0AFF; ordy[1] = 1'b1;
    tick();
    chk("full_pop_level", 32'(lv[1]), 32'd7);
    chk("full_pop_ready", 32'(ir[1]), 32'd1);
    iv[1] = 1'b0;
    repeat (8) tick();
    chk("drain_count", 32'(ncap[1]), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("drain_%0d", i), 32'(cap[1][i]),
          32'(16'h0A00 + i));

    // Wrap-around on B with toggling out_ready; random traffic on A.
    ncap[1] = 0;
    sent = 0;
    for (int c = 0; c < 200 && ncap[1] < 20; c++) begin
      ordy[1] = (c % 2 == 1);
      iv[1] = (sent < 20);
      id[1] = W'(16'h0100 + sent);
      iv[0] = ($urandom % 2 == 0);
      id[0] = W'($urandom);
      ordy[0] = ($urandom % 2 == 0);
      acc = iv[1] && ir[1];
      tick();
      if (acc) sent++;
    end
    iv[1] = 1'b0; ordy[1] = 1'b0;
    chk("wrap_count", 32'(ncap[1]), 32'd20);
    for (int i = 0; i < 20; i++)
      chk($sformatf("wrap_%0d", i), 32'(cap[1][i]),
          32'(16'h0100 + i));

    // restart mid-stream on A.
    rs[0] = 1'b1; iv[0] = 1'b0; ordy[0] = 1'b0;
    tick();
    rs[0] = 1'b0;
    ordy[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[0] = (k < 2);
      id[0] = W'(16'h0C00 + k);
      tick();
    end
    chk("pre_restart_level", 32'(lv[0]), 32'd2);
    rs[0] = 1'b1; iv[0] = 1'b1; id[0] = 16'hDEAD;
    tick();
    rs[0] = 1'b0;
    chk("restart_level", 32'(lv[0]), 32'd0);
    chk("restart_done", 32'(pd[0]), 32'd0);
    chk("restart_valid", 32'(ov[0]), 32'd1);
    ncap[0] = 0;
    for (int k = 0; k < 8; k++) begin
      iv[0] = (k < 2);
      id[0] = W'(16'h0B00 + k);
      tick();
    end
    iv[0] = 1'b0;
    chk("restart_count", 32'(ncap[0]), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("restart_%0d", i), 32'(cap[0][i]),
          (i < 4) ? 32'd0 : 32'(16'h0B00 + i - 4));

    // Randomised traffic with occasional restarts.
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d] = ($urandom % 4 != 0);
        id[d] = W'($urandom);
        ordy[d] = ((c / 256) % 2 == 0) ? ($urandom % 3 != 0)
                                       : ($urandom % 4 == 0);
        rs[d] = ($urandom % 64 == 0);
      end
      tick();
    end

    // Async reset mid-transfer with level=5 on both.
    for (int d = 0; d < 2; d++) begin
      rs[d] = 1'b1; iv[d] = 1'b0; ordy[d] = 1'b0;
    end
    tick();
    for (int k = 0; k < 5; k++) begin
      for (int d = 0; d < 2; d++) begin
        rs[d] = 1'b0; iv[d] = 1'b1; id[d] = W'(16'h0E00 + k);
      end
      tick();
    end
    iv[0] = 1'b0; iv[1] = 1'b0;
    chk("pre_async_level_a", 32'(lv[0]), 32'd5);
    chk("pre_async_level_b", 32'(lv[1]), 32'd5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_a_level", 32'(lv[0]), 32'd0);
    chk("async_a_valid", 32'(ov[0]), 32'd1);
    chk("async_a_data", 32'(od[0]), 32'd0);
    chk("async_a_ready", 32'(ir[0]), 32'd1);
    chk("async_a_done", 32'(pd[0]), 32'd0);
    chk("async_b_level", 32'(lv[1]), 32'd0);
    chk("async_b_valid", 32'(ov[1]), 32'd0);
    chk("async_b_done", 32'(pd[1]), 32'd1);
    tick();
    rst_n = 1'b1;
    iv[1] = 1'b1; id[1] = 16'h5A5A; ordy[1] = 1'b1;
    chk("d0_push_cycle_valid", 32'(ov[1]), 32'd0);
    tick();
    iv[1] = 1'b0;
    chk("d0_next_valid", 32'(ov[1]), 32'd1);
    chk("d0_next_data", 32'(od[1]), 32'h5A5A);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
